comp_enc: RTL

Multi-cycle magnitude comparator that produces the `less` / `eql` flag pair consumed by the comparison decoder (`comp_dcd`). It sits on the execute path between the operand registers and the decoder. It compares two operands MSB-first, one digit per cycle, optionally as signed values. It uses a start/done handshake, so the control unit can stall while a compare is in flight.

---
 rtl/comp_pkg.sv | 18 +
 rtl/comp_digit.sv | 14 +
 rtl/comp_enc.sv | 126 ++++++++++++
 3 files changed

// File: rtl/comp_pkg.sv
// Shared types for the compare encoder/decoder pair: FSM states and the
// condition codes that comp_dcd decodes against the less/eql flag pair.
package comp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [2:0] CMP_GT = 3'b000;
   localparam logic [2:0] CMP_GE = 3'b001;
   localparam logic [2:0] CMP_LT = 3'b010;
   localparam logic [2:0] CMP_LE = 3'b011;
   localparam logic [2:0] CMP_EQ = 3'b100;
   localparam logic [2:0] CMP_NE = 3'b101;

endpackage

// File: rtl/comp_digit.sv
// Combinational single-digit magnitude compare used by the comp_enc digit loop.
module comp_digit #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] da,
   input  logic [DIGIT-1:0] db,
   output logic             lt,
   output logic             eq
);

   assign lt = (da < db);
   assign eq = (da == db);

endmodule

// File: rtl/comp_enc.sv
// Multi-cycle MSB-first magnitude comparator with start/done handshake.
// Build option: define COMP_ENC_EARLY_EXIT_EN to finish on the first differing digit.
module comp_enc
   import comp_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             signed_cmp,
   output logic             busy,
   output logic             done,
   output logic             less_out,
   output logic             eql_out
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = $clog2(N + 1);
   localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};
`ifdef COMP_ENC_EARLY_EXIT_EN
   localparam logic EARLY = 1'b1;
`else
   localparam logic EARLY = 1'b0;
`endif

   state_t           state_r, state_s;
   logic [CW-1:0]    cnt_r, cnt_s;
   logic [WIDTH-1:0] sa_r, sa_s, sb_r, sb_s;
   logic             less_r, less_s, decided_r, decided_s;
   logic             less_out_s, eql_out_s;
   logic             lt_s, eq_s, hit_s, last_s;

   comp_digit #(.DIGIT(DIGIT)) u_digit (
      .da (sa_r[WIDTH-1 -: DIGIT]),
      .db (sb_r[WIDTH-1 -: DIGIT]),
      .lt (lt_s),
      .eq (eq_s)
   );

   // Next-state, datapath and flag computation
   always_comb begin
      state_s    = state_r;
      cnt_s      = cnt_r;
      sa_s       = sa_r;
      sb_s       = sb_r;
      less_s     = less_r;
      decided_s  = decided_r;
      less_out_s = less_out;
      eql_out_s  = eql_out;
      hit_s      = !decided_r && !eq_s;
      last_s     = (cnt_r == CW'(N - 1));
      case (state_r)
         IDLE, DONE: begin
            if (start) begin
               // Offset-binary: flipping both MSBs makes a signed compare unsigned
               state_s    = RUN;
               cnt_s      = '0;
               sa_s       = signed_cmp ? (a ^ MSB_MASK) : a;
               sb_s       = signed_cmp ? (b ^ MSB_MASK) : b;
               less_s     = 1'b0;
               decided_s  = 1'b0;
               less_out_s = 1'b0;
               eql_out_s  = 1'b0;
            end else if (state_r == DONE) begin
               state_s = IDLE;
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            sa_s  = sa_r << DIGIT;
            sb_s  = sb_r << DIGIT;
            cnt_s = cnt_r + CW'(1);
            if (hit_s) begin
               decided_s = 1'b1;
               less_s    = lt_s;
            end else begin
               decided_s = decided_r;
               less_s    = less_r;
            end
            if (last_s || (EARLY && hit_s)) begin
               state_s    = DONE;
               eql_out_s  = !decided_s;
               less_out_s = less_s && decided_s;
            end else begin
               state_s = RUN;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, datapath and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         cnt_r     <= '0;
         sa_r      <= '0;
         sb_r      <= '0;
         less_r    <= 1'b0;
         decided_r <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         less_out  <= 1'b0;
         eql_out   <= 1'b0;
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         sa_r      <= sa_s;
         sb_r      <= sb_s;
         less_r    <= less_s;
         decided_r <= decided_s;
         busy      <= (state_s == RUN);
         done      <= (state_s == DONE);
         less_out  <= less_out_s;
         eql_out   <= eql_out_s;
      end
   end

endmodule
